hello_seq_ctrl: RTL

Sequencer that runs the `hello` cell (1-bit input A, 1-bit output B) through a parameterised stimulus pattern and checks the response in hardware. On each start it drives A through STEPS values, holding each for HOLD cycles. At the end of each hold window it samples B against an expected bit and accumulates a mismatch count. It sits alongside `hello` as its self-test/configuration controller, replacing the fixed-delay bench sequence with a synthesizable one.

---
 rtl/hello_seq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hello_seq_ctrl.sv
// ============================================================================
// hello_seq_ctrl
// ----------------------------------------------------------------------------
// Self-test and configuration sequencer for the `hello` cell, which has a
// 1-bit input A and a 1-bit output B. Each run drives A through STEPS pattern
// values and holds each value for HOLD cycles. In the last cycle of every hold
// window the sequencer samples B, compares it with the expected bit for that
// step, and adds any mismatch to a saturating error count.
//
// Parameters:
//   STEPS    number of pattern steps (1..16)
//   HOLD     cycles each step is held (>= 1)
//   PATTERN  bit i = value driven on A during step i
//   EXPECT   bit i = value B must show at the end of step i
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a run; sampled only while idle
//   abort     in   terminate a run in progress
//   drv_a     out  drives `hello` input A
//   obs_b     in   observes `hello` output B
//   busy      out  run in progress
//   done      out  sticky: last run completed all steps
//   pass      out  sticky: last run completed with err_cnt == 0
//   aborted   out  sticky: last run was aborted
//   err_cnt   out  mismatch count of the current/last run, saturates at 255
//   step_idx  out  current step index
// ============================================================================
module hello_seq_ctrl #(
  parameter int unsigned      STEPS   = 3,
  parameter int unsigned      HOLD    = 20,
  parameter logic [STEPS-1:0] PATTERN = 3'b010,
  parameter logic [STEPS-1:0] EXPECT  = 3'b010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       drv_a,
  input  logic       obs_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       aborted,
  output logic [7:0] err_cnt,
  output logic [3:0] step_idx
);

  // The hold counter only has to reach HOLD-1, so HOLD == 1 still needs one
  // bit to keep the declaration legal.
  localparam int unsigned     CNT_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [3:0]      STEP_LAST = 4'(STEPS - 1);

  // The pattern tables are widened to 16 bits, which lets the 4-bit step index
  // select a bit directly for every legal STEPS.
  localparam logic [15:0] PATTERN_EXT = 16'(PATTERN);
  localparam logic [15:0] EXPECT_EXT  = 16'(EXPECT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [8:0] err_inc;
  logic [7:0] err_sat;
  logic       sample_miss;
  logic [7:0] err_next;
  logic [3:0] step_next;

  // Next-value helpers for the end of a hold window. The increment is formed
  // at 9 bits so that the carry out of 255 shows up and can clamp the count.
  always_comb begin
    err_inc     = {1'b0, err_cnt} + 9'd1;
    err_sat     = err_inc[8] ? 8'hFF : err_inc[7:0];
    sample_miss = (obs_b != EXPECT_EXT[step_idx]);
    err_next    = sample_miss ? err_sat : err_cnt;
    step_next   = step_idx + 4'd1;
  end

  // Sequencer FSM. All outputs are registered here.
  // IDLE holds the sticky result flags until the next start. RUN counts out
  // each hold window and then either advances to the next step or retires the
  // run. An abort is taken before any sampling, so the abort edge never
  // touches err_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      drv_a    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      aborted  <= 1'b0;
      err_cnt  <= 8'd0;
      step_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // start takes precedence over abort here; abort has no meaning
          // while idle.
          if (start) begin
            state    <= RUN;
            cnt      <= '0;
            drv_a    <= PATTERN_EXT[0];
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            aborted  <= 1'b0;
            err_cnt  <= 8'd0;
            step_idx <= 4'd0;
          end else begin
            drv_a <= 1'b0;
          end
        end

        RUN: begin
          if (abort) begin
            // err_cnt and step_idx are left as they are so the partial
            // result can still be inspected.
            state   <= IDLE;
            drv_a   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            aborted <= 1'b1;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Last cycle of the hold window: take the sample, then either
            // move to the next step or finish the run.
            err_cnt <= err_next;
            if (step_idx < STEP_LAST) begin
              step_idx <= step_next;
              cnt      <= '0;
              drv_a    <= PATTERN_EXT[step_next];
            end else begin
              // pass is based on the count that includes this final sample.
              state <= IDLE;
              cnt   <= '0;
              drv_a <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end
          end
        end

        default: begin
          state <= IDLE;
          drv_a <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
